// File: rtl/div_manager.sv
// ---------------------------------------------------------------------------
// div_manager
//
// Multi-cycle RV32M divide unit sitting beside the EX stage. The unit accepts
// one DIV/DIVU/REM/REMU op when idle. It runs a 32-step restoring division
// (one step per clock) and then presents the sign-corrected result on a
// writeback port. Divide-by-zero and the signed-overflow case skip the
// iterative phase and produce their architectural result one edge after
// start.
//
// While an op is in flight, a one-hot scoreboard of the pending destination
// register is exported. The stall controller uses it to hold back dependent
// instructions.
//
// Writeback handshake: wb_valid_o is high while a finished result for a
// non-x0 destination is held. wb_data_o and wb_rd_addr_o are stable for as
// long as wb_valid_o stays high. The result is consumed on the rising edge
// where wb_valid_o && wb_ack_i. wb_ack_i has no effect while wb_valid_o is
// low. Results destined for x0 are dropped after a single cycle in DONE.
//
// Ports
//   clk              clock, all state changes on the rising edge
//   rst              asynchronous active-low reset
//   start_i          issue strobe, honoured only when idle
//   op_i             00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend_i       rs1 value
//   divisor_i        rs2 value
//   rd_addr_i        destination register of the issued op
//   busy_o           high whenever the unit is not idle
//   rd_addr_flags_o  one-hot pending destination (bit 0 never set)
//   wb_valid_o       result available for writeback
//   wb_rd_addr_o     writeback destination
//   wb_data_o        writeback data
//   wb_ack_i         writeback port accepted the result this cycle
//   dbg_state_o      current FSM state (0 IDLE, 1 CALC, 2 DONE)
// ---------------------------------------------------------------------------
module div_manager #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic [4:0]      rd_addr_i,
    output logic            busy_o,
    output logic [31:0]     rd_addr_flags_o,
    output logic            wb_valid_o,
    output logic [4:0]      wb_rd_addr_o,
    output logic [XLEN-1:0] wb_data_o,
    input  logic            wb_ack_i,
    output logic [1:0]      dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [5:0]      count;
    // quo_q starts holding the dividend magnitude. Each step shifts its MSB
    // into the partial remainder and shifts a quotient bit in at the LSB.
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN:0]   rem_q;
    logic            is_rem;
    logic            neg_quo;
    logic            neg_rem;

    // ---------------------------------------------------------------------
    // Issue-time decode
    // ---------------------------------------------------------------------
    logic            signed_op;
    logic            div_by_zero;
    logic            overflow;
    logic [XLEN-1:0] dividend_mag;
    logic [XLEN-1:0] divisor_mag;
    logic [XLEN-1:0] special_result;
    logic [31:0]     flag_set;

    always_comb begin
        signed_op    = ~op_i[0];
        div_by_zero  = (divisor_i == '0);
        overflow     = signed_op && (dividend_i == 32'h8000_0000)
                                 && (divisor_i == 32'hFFFF_FFFF);
        dividend_mag = (signed_op && dividend_i[XLEN-1]) ? (~dividend_i + 1'b1) : dividend_i;
        divisor_mag  = (signed_op && divisor_i[XLEN-1])  ? (~divisor_i + 1'b1)  : divisor_i;

        // The divide-by-zero result is the same for signed and unsigned ops.
        if (div_by_zero) begin
            special_result = op_i[1] ? dividend_i : 32'hFFFF_FFFF;
        end else begin
            special_result = op_i[1] ? 32'h0000_0000 : 32'h8000_0000;
        end

        // x0 is never a real dependency, so its bit is masked off.
        flag_set = (32'd1 << rd_addr_i) & ~32'd1;
    end

    // ---------------------------------------------------------------------
    // One restoring-division step
    // ---------------------------------------------------------------------
    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   rem_trial;
    logic [XLEN:0]   rem_next;
    logic [XLEN-1:0] quo_next;
    logic [XLEN-1:0] quo_fixed;
    logic [XLEN-1:0] rem_fixed;
    logic [XLEN-1:0] calc_result;

    always_comb begin
        rem_shift = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
        rem_trial = rem_shift - {1'b0, dvs_q};
        // The partial remainder is always below the divisor, so bit XLEN of
        // the trial is a clean borrow flag.
        if (!rem_trial[XLEN]) begin
            rem_next = rem_trial;
            quo_next = {quo_q[XLEN-2:0], 1'b1};
        end else begin
            rem_next = rem_shift;
            quo_next = {quo_q[XLEN-2:0], 1'b0};
        end

        // Sign correction is applied to the outcome of the final step, so the
        // corrected value lands in wb_data_o on the edge that enters DONE.
        quo_fixed   = neg_quo ? (~quo_next + 1'b1) : quo_next;
        rem_fixed   = neg_rem ? (~rem_next[XLEN-1:0] + 1'b1) : rem_next[XLEN-1:0];
        calc_result = is_rem ? rem_fixed : quo_fixed;
    end

    // ---------------------------------------------------------------------
    // Writeback / handshake
    // ---------------------------------------------------------------------
    logic done_exit;

    always_comb begin
        wb_valid_o  = (state == DONE) && (wb_rd_addr_o != 5'd0);
        // x0 results are dropped after one cycle. Other results leave DONE
        // only once they have been accepted.
        done_exit   = (state == DONE) && ((wb_rd_addr_o == 5'd0) || wb_ack_i);
        busy_o      = (state != IDLE);
        dbg_state_o = state;
    end

    // ---------------------------------------------------------------------
    // FSM and datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            count           <= 6'd0;
            quo_q           <= '0;
            dvs_q           <= '0;
            rem_q           <= '0;
            is_rem          <= 1'b0;
            neg_quo         <= 1'b0;
            neg_rem         <= 1'b0;
            rd_addr_flags_o <= 32'd0;
            wb_rd_addr_o    <= 5'd0;
            wb_data_o       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        wb_rd_addr_o    <= rd_addr_i;
                        rd_addr_flags_o <= flag_set;
                        is_rem          <= op_i[1];
                        neg_quo         <= signed_op && (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]);
                        neg_rem         <= signed_op && dividend_i[XLEN-1];
                        if (div_by_zero || overflow) begin
                            state     <= DONE;
                            wb_data_o <= special_result;
                        end else begin
                            state <= CALC;
                            quo_q <= dividend_mag;
                            dvs_q <= divisor_mag;
                            rem_q <= '0;
                            count <= 6'd0;
                        end
                    end
                end

                CALC: begin
                    rem_q <= rem_next;
                    quo_q <= quo_next;
                    if (count == 6'd31) begin
                        state     <= DONE;
                        count     <= 6'd0;
                        wb_data_o <= calc_result;
                    end else begin
                        count <= count + 6'd1;
                    end
                end

                DONE: begin
                    if (done_exit) begin
                        state           <= IDLE;
                        rd_addr_flags_o <= 32'd0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_manager.sv
module tb_div_manager;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [4:0]  rd_addr_i;
  logic        busy_o;
  logic [31:0] rd_addr_flags_o;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_addr_o;
  logic [31:0] wb_data_o;
  logic        wb_ack_i;
  logic [1:0]  dbg_state_o;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  div_manager dut (
    .clk             (clk),
    .rst             (rst),
    .start_i         (start_i),
    .op_i            (op_i),
    .dividend_i      (dividend_i),
    .divisor_i       (divisor_i),
    .rd_addr_i       (rd_addr_i),
    .busy_o          (busy_o),
    .rd_addr_flags_o (rd_addr_flags_o),
    .wb_valid_o      (wb_valid_o),
    .wb_rd_addr_o    (wb_rd_addr_o),
    .wb_data_o       (wb_data_o),
    .wb_ack_i        (wb_ack_i),
    .dbg_state_o     (dbg_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // reference model: plain 64-bit arithmetic plus the architectural corner cases
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return op[1] ? r[31:0] : q[31:0];
  endfunction

  function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // driver: issue one op in "cycle 0", follow it to completion.
  // hold = number of cycles wb_ack_i stays low after wb_valid_o rises.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int hold);
    logic [31:0] exp_f;
    logic [31:0] got_d;
    int lat;
    int bad;
    lat   = is_special(op, a, b) ? 1 : 33;
    exp_f = (rd == 5'd0) ? 32'd0 : (32'd1 << rd);
    if (rd != 5'd0) exp_q.push_back(model(op, a, b));

    @(negedge clk);
    start_i    = 1'b1;
    op_i       = op;
    dividend_i = a;
    divisor_i  = b;
    rd_addr_i  = rd;
    wb_ack_i   = (hold == 0);
    @(negedge clk);
    // cycle 1: scramble inputs so only the latched copy can be used
    start_i    = 1'b0;
    op_i       = 2'($urandom_range(0, 3));
    dividend_i = $urandom;
    divisor_i  = $urandom;
    rd_addr_i  = 5'($urandom_range(0, 31));

    bad = 0;
    for (int cyc = 1; cyc < lat; cyc++) begin
      if (wb_valid_o || !busy_o || rd_addr_flags_o != exp_f) bad++;
      start_i = (cyc == 2);  // start while busy must be ignored
      @(negedge clk);
    end
    start_i = 1'b0;
    check("pre_valid_cycles", bad, 0);

    if (rd == 5'd0) begin
      check("x0_valid", wb_valid_o, 1'b0);
      check("x0_flags", rd_addr_flags_o, 32'd0);
      check("x0_busy_in_done", busy_o, 1'b1);
      @(negedge clk);
      check("x0_busy_after", busy_o, 1'b0);
    end else begin
      check("valid_at_latency", wb_valid_o, 1'b1);
      check("wb_rd_addr", wb_rd_addr_o, rd);
      check("flags_in_done", rd_addr_flags_o, exp_f);
      got_d = wb_data_o;
      check("wb_data", got_d, exp_q.pop_front());
      bad = 0;
      for (int k = 0; k < hold; k++) begin
        start_i = (k == 0);  // start in DONE must be ignored
        @(negedge clk);
        start_i = 1'b0;
        if (!wb_valid_o || wb_data_o != got_d || wb_rd_addr_o != rd || rd_addr_flags_o != exp_f) bad++;
      end
      if (hold > 0) check("hold_stable", bad, 0);
      // ack cycle; a start here coincides with the DONE->IDLE edge and is dropped
      wb_ack_i = 1'b1;
      start_i  = 1'b1;
      @(negedge clk);
      start_i  = 1'b0;
      wb_ack_i = 1'b0;
      check("valid_after_ack", wb_valid_o, 1'b0);
      check("flags_after_ack", rd_addr_flags_o, 32'd0);
      check("busy_after_ack", busy_o, 1'b0);
    end
  endtask

  task automatic reset_mid_calc();
    @(negedge clk);
    start_i    = 1'b1;
    op_i       = 2'b01;
    dividend_i = 32'd1000;
    divisor_i  = 32'd3;
    rd_addr_i  = 5'd12;
    wb_ack_i   = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (14) @(negedge clk);  // now in cycle 15
    check("calc_busy_before_rst", busy_o, 1'b1);
    rst = 1'b0;
    #1;
    check("rst_busy", busy_o, 1'b0);
    check("rst_flags", rd_addr_flags_o, 32'd0);
    check("rst_valid", wb_valid_o, 1'b0);
    check("rst_rd_addr", wb_rd_addr_o, 5'd0);
    check("rst_data", wb_data_o, 32'd0);
    repeat (2) @(negedge clk);
    rst      = 1'b1;
    wb_ack_i = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    int sel;
    rst        = 1'b1;
    start_i    = 1'b0;
    op_i       = 2'b00;
    dividend_i = 32'd0;
    divisor_i  = 32'd0;
    rd_addr_i  = 5'd0;
    wb_ack_i   = 1'b0;
    #3 rst = 1'b0;
    #1;
    check("reset_busy", busy_o, 1'b0);
    check("reset_flags", rd_addr_flags_o, 32'd0);
    check("reset_valid", wb_valid_o, 1'b0);
    check("reset_rd_addr", wb_rd_addr_o, 5'd0);
    check("reset_data", wb_data_o, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // directed cases
    do_op(2'b01, 32'd100, 32'd7, 5'd5, 0);                     // DIVU 100/7 -> 14
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd3, 0);               // REM -7/2 -> -1
    do_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd3, 1);               // DIV -7/2 -> -3
    do_op(2'b01, 32'd1234, 32'd0, 5'd8, 0);                    // DIVU by zero
    do_op(2'b11, 32'd1234, 32'd0, 5'd9, 0);                    // REMU by zero
    do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd31, 0);      // signed overflow
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd30, 2);      // overflow remainder
    do_op(2'b00, 32'd50, 32'd5, 5'd0, 0);                      // rd = x0
    do_op(2'b11, 32'hDEAD_BEEF, 32'd977, 5'd17, 10);           // ack held off 10 cycles
    reset_mid_calc();
    do_op(2'b00, 32'd100, 32'hFFFF_FFF9, 5'd1, 0);             // first op after reset

    // randomized stimulus
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      a   = $urandom;
      b   = $urandom;
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      else if (sel <= 4) b = 32'($urandom_range(1, 300));
      else if (sel == 5) b = 32'd0 - 32'($urandom_range(1, 300));
      do_op(2'($urandom_range(0, 3)), a, b, 5'($urandom_range(0, 31)), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/div_manager.md
DIV_MANAGER -- requirements
Module: div_manager

Interface
REQ-001 XLEN, 32, operand and result width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low.
REQ-004 start_i  input  1  EX stage issues a divide op this cycle.
REQ-005 op_i  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 dividend_i  input  32  rs1 value.
REQ-007 divisor_i  input  32  rs2 value.
REQ-008 rd_addr_i  input  5  destination register of the issued op.
REQ-009 busy_o  output  1  high whenever state is not IDLE.
REQ-010 rd_addr_flags_o  output  32  one-hot pending-rd scoreboard for the stall controller.
REQ-011 wb_valid_o  output  1  result is ready for register-file writeback.
REQ-012 wb_rd_addr_o  output  5  writeback destination.
REQ-013 wb_data_o  output  32  writeback data.
REQ-014 wb_ack_i  input  1  writeback port accepted the result this cycle.

Function
REQ-015 The FSM SHALL have three states, IDLE, CALC and DONE, encoded in a registered state variable.
REQ-016 In IDLE, start_i high SHALL latch op, operands and rd_addr; start_i outside IDLE SHALL be ignored.
REQ-017 Special cases SHALL bypass CALC, going IDLE -> DONE in one edge:
- divisor 0: quotient 0xFFFFFFFF, remainder = dividend.
- DIV/REM with 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
REQ-018 Otherwise the transition SHALL be IDLE -> CALC.
- Operand magnitudes are taken for signed ops.
- A 6-bit iteration counter loads 0.
REQ-019 CALC SHALL perform one restoring-division step per cycle, 32 steps, MSB first.
- A 33-bit partial remainder is used.
- On the edge where the counter equals 31, the state SHALL move to DONE.
REQ-020 On entering DONE, sign correction SHALL be registered into wb_data_o:
- quotient negated when the dividend and divisor signs differ (signed ops only);
- remainder takes the dividend sign.
REQ-021 Latency, with start in cycle 0: wb_valid_o SHALL be high from cycle 33 for a normal op, and from cycle 1 for a special case.
REQ-022 wb_valid_o SHALL equal (state==DONE && pending rd != 0).
REQ-023 wb_data_o and wb_rd_addr_o SHALL hold stable while wb_valid_o is high.
REQ-024 DONE SHALL return to IDLE on the edge where wb_valid_o && wb_ack_i.
- With rd == x0, DONE SHALL return to IDLE unconditionally after one cycle.
REQ-025 Flag set: on the start edge, rd_addr_flags_o[rd_addr_i] SHALL be set, visible from cycle 1; bit 0 SHALL never be set.
REQ-026 Flag clear: the flag SHALL clear on the same edge that DONE exits, so at most one bit is ever set.
REQ-027 A new start_i SHALL NOT be accepted in the cycle of the DONE->IDLE edge; it is accepted only once IDLE is reached.
REQ-028 wb_ack_i while wb_valid_o is low SHALL have no effect.

Reset
REQ-029 Reset SHALL asynchronously force the following, including mid-CALC or mid-DONE, discarding any in-flight op:
- state IDLE, counter 0;
- busy_o 0, rd_addr_flags_o 0;
- wb_valid_o 0, wb_rd_addr_o 0, wb_data_o 0.
REQ-030 The first start_i after reset release SHALL be accepted normally.

Verification
REQ-031 DIVU 100/7, rd=5, start cycle 0, wb_ack_i tied 1 -> all of:
- flags = 0x00000020 in cycles 1-33;
- wb_valid_o high only in cycle 33, with data 14;
- flags = 0 in cycle 34.
REQ-032 REM 0xFFFFFFF9 / 2, rd=3 -> wb_data_o 0xFFFFFFFF (-1); DIV with the same operands -> 0xFFFFFFFD (-3).
REQ-033 Special cases:
- DIVU 1234/0 -> wb_valid_o in cycle 1 with data 0xFFFFFFFF;
- REMU 1234/0 -> data 1234;
- DIV 0x80000000 / 0xFFFFFFFF -> data 0x80000000 in cycle 1.
REQ-034 DIV with rd=0 -> flags remain 0, wb_valid_o never asserts, busy_o falls after DONE.
REQ-035 wb_ack_i held low for 10 cycles after wb_valid_o rises -> outputs stable and flag held for those cycles; both clear on the edge following the ack.
REQ-036 Other control cases:
- rst low in CALC cycle 15 -> all outputs 0 immediately;
- start_i high while busy_o is high -> ignored, no flag change.
